// File: rtl/channel_frame_builder.sv
// Per-channel ADC framer: packs 16-bit samples into 64-bit header/payload/footer frames.
// Optional footer word (sample count + XOR checksum) enabled by defining FRAME_FOOTER_EN.
module channel_frame_builder #(
  parameter int unsigned S_AXIS_TDATA_WIDTH = 64,
  parameter int unsigned SAMPLE_WIDTH       = 16,
  parameter logic [7:0]  CH_ID              = 8'd0,
  parameter int unsigned FRAME_WORDS        = 16
) (
  input  logic                          TX_ACLK,
  input  logic                          TX_ARESET,
  input  logic [SAMPLE_WIDTH-1:0]       SAMPLE_DATA,
  input  logic                          SAMPLE_VALID,
  input  logic                          TRIGGER,
  output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TUSER,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  output logic                          BUSY,
  output logic [15:0]                   DROP_CNT
);

  localparam logic [7:0] LP_LAST = 8'(FRAME_WORDS - 1);
`ifdef FRAME_FOOTER_EN
  localparam logic [15:0] LP_NSAMP = 16'(FRAME_WORDS * 4);
  typedef enum logic [1:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_FOOTER
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_HEADER, S_PAYLOAD
  } state_t;
`endif

  state_t                          r_state;
  logic [31:0]                     r_ts;
  logic [31:0]                     r_ts_lat;
  logic [15:0]                     r_frame_id;
  logic [47:0]                     r_buf;
  logic [1:0]                      r_idx;
  logic [7:0]                      r_word_cnt;
  logic [S_AXIS_TDATA_WIDTH-1:0]   r_tdata;
  logic                            r_tuser;
  logic                            r_tlast;
  logic                            r_tvalid;
  logic [15:0]                     r_drop_cnt;
`ifdef FRAME_FOOTER_EN
  logic [31:0]                     r_xor;
`endif

  logic [S_AXIS_TDATA_WIDTH-1:0]   w_word;
  logic                            w_last_word;
  logic                            w_busy;

  assign w_word      = {SAMPLE_DATA, r_buf};
  assign w_last_word = (r_word_cnt == LP_LAST);
  assign w_busy      = (r_state != S_IDLE);

  // Free-running timestamp, wraps naturally at 32 bits.
  always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
    if (TX_ARESET) r_ts <= '0;
    else           r_ts <= r_ts + 32'd1;
  end

  // Count triggers that arrive while a frame is in flight, saturating.
  always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
    if (TX_ARESET)
      r_drop_cnt <= '0;
    else if (TRIGGER && w_busy && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  // Frame sequencer with registered stream outputs; valid/user/last are one-cycle strobes.
  always_ff @(posedge TX_ACLK or posedge TX_ARESET) begin
    if (TX_ARESET) begin
      r_state    <= S_IDLE;
      r_ts_lat   <= '0;
      r_frame_id <= '0;
      r_buf      <= '0;
      r_idx      <= '0;
      r_word_cnt <= '0;
      r_tdata    <= '0;
      r_tuser    <= 1'b0;
      r_tlast    <= 1'b0;
      r_tvalid   <= 1'b0;
`ifdef FRAME_FOOTER_EN
      r_xor      <= '0;
`endif
    end else begin
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (TRIGGER) begin
            r_ts_lat <= r_ts;
            r_state  <= S_HEADER;
          end
        end
        S_HEADER: begin
          r_tdata  <= {8'hA5, CH_ID, r_frame_id, r_ts_lat};
          r_tuser  <= 1'b1;
          r_tvalid <= 1'b1;
          r_state  <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (SAMPLE_VALID) begin
            if (r_idx == 2'd3) begin
              r_tdata  <= w_word;
              r_tvalid <= 1'b1;
              r_idx    <= 2'd0;
`ifdef FRAME_FOOTER_EN
              r_xor    <= r_xor ^ w_word[63:32] ^ w_word[31:0];
`endif
              if (w_last_word) begin
                r_word_cnt <= '0;
`ifdef FRAME_FOOTER_EN
                r_state    <= S_FOOTER;
`else
                r_tlast    <= 1'b1;
                r_frame_id <= r_frame_id + 16'd1;
                r_state    <= S_IDLE;
`endif
              end else begin
                r_word_cnt <= r_word_cnt + 8'd1;
              end
            end else begin
              r_buf[{r_idx, 4'b0000} +: 16] <= SAMPLE_DATA;
              r_idx <= r_idx + 2'd1;
            end
          end
        end
`ifdef FRAME_FOOTER_EN
        S_FOOTER: begin
          r_tdata    <= {8'h5A, CH_ID, LP_NSAMP, r_xor};
          r_tvalid   <= 1'b1;
          r_tlast    <= 1'b1;
          r_xor      <= '0;
          r_frame_id <= r_frame_id + 16'd1;
          r_state    <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TUSER  = r_tuser;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TVALID = r_tvalid;
  assign BUSY          = w_busy;
  assign DROP_CNT      = r_drop_cnt;

endmodule

// File: tb/tb_channel_frame_builder.sv
// Bench for channel_frame_builder: randomized frames checked against a sample-list model.
// Footer expectations are included when FRAME_FOOTER_EN is defined.
module tb_channel_frame_builder;

  localparam int         FW = 2;
  localparam logic [7:0] CH = 8'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sd  = '0;
  logic        sv  = 1'b0;
  logic        trig = 1'b0;
  logic [63:0] tdata;
  logic        tuser, tlast, tvalid, busy;
  logic [15:0] dcnt;

  channel_frame_builder #(
    .S_AXIS_TDATA_WIDTH(64),
    .SAMPLE_WIDTH(16),
    .CH_ID(CH),
    .FRAME_WORDS(FW)
  ) dut (
    .TX_ACLK(clk),
    .TX_ARESET(rst),
    .SAMPLE_DATA(sd),
    .SAMPLE_VALID(sv),
    .TRIGGER(trig),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TUSER(tuser),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TVALID(tvalid),
    .BUSY(busy),
    .DROP_CNT(dcnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ts = '0;
  logic [15:0] fid = '0;
  int          drop = 0;
  logic [63:0] last_data = '0;
  logic [15:0] seq_val = 16'd1;

  task automatic cyc();
    @(posedge clk);
    ts = ts + 32'd1;
    #1;
  endtask

  task automatic bump_drop();
    if (drop < 65535) drop++;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; sv = 1'b0; sd = '0;
    cyc();
    cyc();
    rst = 1'b0;
    ts = '0; fid = '0; drop = 0; last_data = '0;
  endtask

  task automatic start_frame(input int idle_n, input bit noisy);
    logic [31:0] tl;
    logic [63:0] exp;
    for (int i = 0; i < idle_n; i++) begin
      sv = noisy ? 1'($urandom) : 1'b0;
      sd = 16'($urandom);
      trig = 1'b0;
      cyc();
      checks++;
      if (tvalid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet got tvalid=%b busy=%b exp 0 0", tvalid, busy);
      end
    end
    trig = 1'b1;
    sv = noisy ? 1'($urandom) : 1'b0;
    sd = 16'($urandom);
    tl = ts;
    cyc();
    trig = noisy ? 1'($urandom) : 1'b0;
    if (trig) bump_drop();
    sv = noisy ? 1'($urandom) : 1'b0;
    sd = 16'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hdr_busy got=%b exp=1", busy);
    end
    cyc();
    trig = 1'b0;
    sv = 1'b0;
    exp = {8'hA5, CH, fid, tl};
    last_data = exp;
    checks++;
    if (tvalid !== 1'b1 || tuser !== 1'b1 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL hdr_flags got v/u/l=%b%b%b exp 110", tvalid, tuser, tlast);
    end
    checks++;
    if (tdata !== exp) begin
      failures++;
      $display("FAIL hdr_tdata got=%h exp=%h", tdata, exp);
    end
  endtask

  task automatic run_payload(input int vpct, input int tpct,
                             input bit seq, input bit trig_last);
    int          total;
    int          cnt;
    int          guard;
    bit          vld, t, emit, is_last;
    logic [15:0] smp;
    logic [15:0] lane [4];
    logic [63:0] w;
    logic [31:0] xacc;
    total = FW * 4;
    cnt = 0;
    guard = 0;
    xacc = '0;
    for (int i = 0; i < 4; i++) lane[i] = '0;
    while (cnt < total && guard < 5000) begin
      guard++;
      vld = ($urandom_range(99) < vpct);
      t = ($urandom_range(99) < tpct);
      smp = seq ? seq_val : 16'($urandom);
`ifndef FRAME_FOOTER_EN
      if (vld && cnt == total - 1 && trig_last) t = 1'b1;
`endif
      sv = vld; sd = smp; trig = t;
      if (t) bump_drop();
      if (vld) begin
        lane[cnt % 4] = smp;
        cnt++;
        if (seq) seq_val = seq_val + 16'd1;
      end
      cyc();
      emit = vld && (cnt % 4 == 0);
      is_last = emit && (cnt == total);
      if (emit) begin
        w = {lane[3], lane[2], lane[1], lane[0]};
        xacc = xacc ^ w[63:32] ^ w[31:0];
        last_data = w;
      end
      checks++;
      if (tvalid !== emit) begin
        failures++;
        $display("FAIL pay_tvalid got=%b exp=%b cnt=%0d", tvalid, emit, cnt);
      end
      checks++;
      if (tdata !== last_data) begin
        failures++;
        $display("FAIL pay_tdata got=%h exp=%h", tdata, last_data);
      end
      if (emit) begin
        checks++;
`ifdef FRAME_FOOTER_EN
        if (tuser !== 1'b0 || tlast !== 1'b0) begin
`else
        if (tuser !== 1'b0 || tlast !== is_last) begin
`endif
          failures++;
          $display("FAIL pay_flags got u/l=%b%b last=%b", tuser, tlast, is_last);
        end
      end
    end
    if (cnt < total) begin
      failures++;
      $display("FAIL pay_timeout got=%0d samples exp=%0d", cnt, total);
    end
    sv = 1'b0;
    trig = 1'b0;
`ifdef FRAME_FOOTER_EN
    trig = trig_last;
    if (trig) bump_drop();
    cyc();
    trig = 1'b0;
    w = {8'h5A, CH, 16'(FW * 4), xacc};
    last_data = w;
    checks++;
    if (tvalid !== 1'b1 || tlast !== 1'b1 || tuser !== 1'b0 || tdata !== w) begin
      failures++;
      $display("FAIL footer got=%h v/l/u=%b%b%b exp=%h 110", tdata, tvalid, tlast, tuser, w);
    end
`endif
    fid = fid + 16'd1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL end_busy got=%b exp=0", busy);
    end
    checks++;
    if (dcnt !== 16'(drop)) begin
      failures++;
      $display("FAIL end_drop got=%0d exp=%0d", dcnt, drop);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; trig = 1'b1; sv = 1'b1; sd = 16'hBEEF;
    cyc();
    cyc();
    checks++;
    if (tdata !== 64'd0 || tvalid !== 1'b0 || tuser !== 1'b0) begin
      failures++;
      $display("FAIL rst_data got=%h v=%b u=%b exp 0", tdata, tvalid, tuser);
    end
    checks++;
    if (tlast !== 1'b0 || busy !== 1'b0 || dcnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_ctrl got l=%b b=%b d=%0d exp 0", tlast, busy, dcnt);
    end
    trig = 1'b0; sv = 1'b0;
    rst = 1'b0;
    ts = '0; fid = '0; drop = 0; last_data = '0;
  endtask

  task automatic test_basic_frame();
    do_reset();
    seq_val = 16'd1;
    start_frame(10, 1'b0);
    run_payload(100, 0, 1'b1, 1'b0);
  endtask

  task automatic test_frame_id();
    start_frame(3, 1'b1);
    run_payload(70, 20, 1'b0, 1'b0);
    start_frame(1, 1'b1);
    run_payload(60, 30, 1'b0, 1'b0);
  endtask

  task automatic test_drop_cnt();
    do_reset();
    start_frame(2, 1'b0);
    sv = 1'b0;
    trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bump_drop();
      cyc();
    end
    trig = 1'b0;
    checks++;
    if (dcnt !== 16'(drop) || dcnt !== 16'd5) begin
      failures++;
      $display("FAIL drop_five got=%0d exp=%0d", dcnt, drop);
    end
    trig = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      bump_drop();
      cyc();
    end
    trig = 1'b0;
    checks++;
    if (dcnt !== 16'(drop)) begin
      failures++;
      $display("FAIL drop_sat got=%h exp=%h", dcnt, 16'(drop));
    end
    run_payload(100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    seq_val = 16'h0100;
    start_frame(1, 1'b1);
    run_payload(33, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_frame(2, 1'b0);
    run_payload(100, 0, 1'b0, 1'b1);
    start_frame(0, 1'b0);
    run_payload(50, 10, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    start_frame(1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sv = 1'b1;
      sd = 16'($urandom);
      cyc();
    end
    sv = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (tdata !== 64'd0 || tvalid !== 1'b0 || tuser !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out got=%h v/u/l=%b%b%b exp 0", tdata, tvalid, tuser, tlast);
    end
    checks++;
    if (busy !== 1'b0 || dcnt !== 16'd0) begin
      failures++;
      $display("FAIL midrst_ctrl got b=%b d=%0d exp 0", busy, dcnt);
    end
    cyc();
    rst = 1'b0;
    ts = '0; fid = '0; drop = 0; last_data = '0;
    seq_val = 16'h0A00;
    start_frame(4, 1'b0);
    run_payload(100, 0, 1'b1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_frame_id();
    test_drop_cnt();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
